yarvi_mem_arb: RTL and testbench
================================

YARVI_MEM_ARB -- requirements
Module: yarvi_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: number of consecutive cycles B may lose arbitration before it is forced a grant.
REQ-002 Port clock, input, 1: single clock; all state on rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Ports a_valid, input, 1; a_ready, output, 1: requester A (load-store unit) request handshake.
REQ-005 Ports a_write, input, 1; a_address, input, 32; a_writedata, input, 32; a_writemask, input, 4: requester A command.
REQ-006 Ports a_rvalid, output, 1; a_rdata, output, 32: requester A load response.
REQ-007 Ports b_valid, b_ready, b_write, b_address, b_writedata, b_writemask, b_rvalid, b_rdata: requester B (debug/loader); widths and directions identical to A.
REQ-008 Ports m_valid, output, 1; m_ready, input, 1: memory-side command handshake.
REQ-009 Ports m_write, output, 1; m_address, output, 32; m_writedata, output, 32; m_writemask, output, 4: memory-side command.
REQ-010 Port m_rdata, input, 32: read data, valid exactly one cycle after an accepted read command.

Function
REQ-011 Transfer on any port occurs only in a cycle where valid and ready are both high.
REQ-012 Command stage is a single register: m_* are registered; stage free when !m_valid or m_ready.
REQ-013 a_ready = stage free and grant to A; b_ready = stage free and grant to B; at most one high per cycle.
REQ-014 Grant: A wins when a_valid, unless the starvation override (REQ-016) is active; B wins when b_valid and (not a_valid or override).
REQ-015 Accepted command appears on m_* the following cycle and holds stable while m_valid & !m_ready.
REQ-016 Starvation counter: increments each cycle b_valid is high, stage is free, and A is granted; clears when B is granted or b_valid is low; override is active when counter == STARVE_MAX.
REQ-017 Counter saturates at STARVE_MAX; it does not wrap.
REQ-018 Counter holds while the stage is stalled (m_valid & !m_ready).
REQ-019 Response tag (owner, is_read) is captured when m_valid & m_ready; the next cycle, the owner's rvalid equals is_read and its rdata equals m_rdata.
REQ-020 Non-owner rvalid is 0; both rdata outputs always reflect m_rdata (don't-care when rvalid is 0).
REQ-021 Load latency from request handshake to rvalid is 2 cycles with m_ready held high.
REQ-022 Writes produce no response; m_writemask is forced to 0 for reads.
REQ-023 Back-to-back accepts are supported: full throughput of one command per cycle while m_ready is high.
REQ-024 Simultaneous a_valid and b_valid with the override inactive: A granted, B counted per REQ-016.

Reset
REQ-025 While reset_n is low: m_valid, a_rvalid, b_rvalid, a_ready, b_ready, m_write, and m_writemask are 0; m_address and m_writedata are 0; counter and response tag are cleared.
REQ-026 Reset asserted mid-transaction discards the pending command and response; no rvalid is emitted after release.
REQ-027 First grant is possible in the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro YARVI_MEM_ARB_STARVE_EN defined: starvation counter and override are present per REQ-016 to REQ-018.
REQ-029 Macro undefined: counter is absent, arbitration is strict priority A > B, and STARVE_MAX is ignored.

Verification
REQ-030 A reads 0x80000010 after reset, m_ready=1, m_rdata=0x12345678 at response cycle -> a_rvalid=1 two cycles after handshake, a_rdata=0x12345678, b_rvalid=0.
REQ-031 A and B valid continuously, STARVE_EN, STARVE_MAX=4, m_ready=1 -> grant pattern A,A,A,A,B repeating; counter never exceeds 4.
REQ-032 Same stimulus as REQ-031 without the macro -> B never granted while a_valid is high.
REQ-033 B write 0xCAFEF00D mask 0xF to 0x80000100, m_ready low 3 cycles -> m_* stable for 3 cycles, a_ready=b_ready=0, no rvalid, transfer completes on the 4th cycle.
REQ-034 A read accepted, reset_n pulled low the next cycle -> all outputs 0 per REQ-025, no a_rvalid after release.
REQ-035 Alternating A read / B read each cycle, m_ready=1 -> each rvalid is routed to the correct owner with matching m_rdata, one per cycle.

Source files
------------

// File: rtl/yarvi_mem_arb.sv
// yarvi_mem_arb: two-requester memory arbiter (A = load-store unit, B = debug/loader)
// with a single registered command stage and a one-entry response tag.
// Optional macro YARVI_MEM_ARB_STARVE_EN adds a B-starvation counter that forces a
// grant to B after STARVE_MAX consecutive lost arbitrations. Without the macro the
// priority is strictly A > B and STARVE_MAX has no effect.
module yarvi_mem_arb #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   // requester A
   input  logic        a_valid,
   output logic        a_ready,
   input  logic        a_write,
   input  logic [31:0] a_address,
   input  logic [31:0] a_writedata,
   input  logic [3:0]  a_writemask,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,
   // requester B
   input  logic        b_valid,
   output logic        b_ready,
   input  logic        b_write,
   input  logic [31:0] b_address,
   input  logic [31:0] b_writedata,
   input  logic [3:0]  b_writemask,
   output logic        b_rvalid,
   output logic [31:0] b_rdata,
   // memory side
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_write,
   output logic [31:0] m_address,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_writemask,
   input  logic [31:0] m_rdata
);

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_e;

   typedef struct packed {
      owner_e      owner;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  writemask;
   } cmd_t;

   logic   stage_free;
   logic   override;
   logic   grant_a;
   logic   grant_b;
   logic   m_valid_q, m_valid_d;
   cmd_t   cmd_q, cmd_d;
   logic   rsp_read_q, rsp_read_d;
   owner_e rsp_owner_q, rsp_owner_d;

   // The command register can take a new command when it is empty or draining this cycle.
   assign stage_free = !m_valid_q || m_ready;

`ifdef YARVI_MEM_ARB_STARVE_EN
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_q, starve_d;

   assign override = (starve_q == CW'(STARVE_MAX));

   // Count cycles where B waits while A takes the free stage; freeze while stalled.
   always_comb begin
      starve_d = starve_q;
      if (stage_free) begin
         if (b_valid && grant_a)
            starve_d = override ? starve_q : starve_q + 1'b1;
         else
            starve_d = '0;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) starve_q <= '0;
      else          starve_q <= starve_d;
   end
`else
   logic unused_starve_max;

   assign override          = 1'b0;
   assign unused_starve_max = (STARVE_MAX != 0);
`endif

   // A only yields when the override is active and B actually wants the stage.
   assign grant_a = a_valid && !(override && b_valid);
   assign grant_b = b_valid && !grant_a;

   // Ready is gated by reset so neither requester sees a handshake while held in reset.
   assign a_ready = reset_n && stage_free && grant_a;
   assign b_ready = reset_n && stage_free && grant_b;

   // Load the stage from the winning requester; reads never carry a byte mask.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      cmd_d     = cmd_q;
      m_valid_d = m_valid_q && !m_ready;
      if (a_ready) begin
         m_valid_d = 1'b1;
         cmd_d     = '{owner: OWN_A, write: a_write, address: a_address,
                       writedata: a_writedata,
                       writemask: a_write ? a_writemask : 4'h0};
      end else if (b_ready) begin
         m_valid_d = 1'b1;
         cmd_d     = '{owner: OWN_B, write: b_write, address: b_address,
                       writedata: b_writedata,
                       writemask: b_write ? b_writemask : 4'h0};
      end
   end

   // Command stage register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: the datapath fields are reset too, because the memory side must see zeros during reset.
      if (!reset_n) begin
         m_valid_q <= 1'b0;
         cmd_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         cmd_q     <= cmd_d;
      end
   end

   // Tag the command leaving the stage so its read data can be routed next cycle.
   always_comb begin
      rsp_read_d  = m_valid_q && m_ready && !cmd_q.write;
      rsp_owner_d = (m_valid_q && m_ready) ? cmd_q.owner : rsp_owner_q;
   end

   // Response tag register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_read_q  <= 1'b0;
         rsp_owner_q <= OWN_A;
      end else begin
         rsp_read_q  <= rsp_read_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   assign m_valid     = m_valid_q;
   assign m_write     = cmd_q.write;
   assign m_address   = cmd_q.address;
   assign m_writedata = cmd_q.writedata;
   assign m_writemask = cmd_q.writemask;

   assign a_rvalid = rsp_read_q && (rsp_owner_q == OWN_A);
   assign b_rvalid = rsp_read_q && (rsp_owner_q == OWN_B);
   assign a_rdata  = m_rdata;
   assign b_rdata  = m_rdata;

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Testbench for yarvi_mem_arb: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model (pending command, starvation count,
// pending response). Honours YARVI_MEM_ARB_STARVE_EN the same way as the design.
module tb_yarvi_mem_arb;

   localparam int STARVE_MAX = 4;
`ifdef YARVI_MEM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid, a_ready, a_write, a_rvalid;
   logic [31:0] a_address, a_writedata, a_rdata;
   logic [3:0]  a_writemask;
   logic        b_valid, b_ready, b_write, b_rvalid;
   logic [31:0] b_address, b_writedata, b_rdata;
   logic [3:0]  b_writemask;
   logic        m_valid, m_ready, m_write;
   logic [31:0] m_address, m_writedata, m_rdata;
   logic [3:0]  m_writemask;

   always #5 clock = ~clock;

   yarvi_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_address(a_address),
      .a_writedata(a_writedata), .a_writemask(a_writemask), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_address(b_address),
      .b_writedata(b_writedata), .b_writemask(b_writemask), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_address(m_address),
      .m_writedata(m_writedata), .m_writemask(m_writemask), .m_rdata(m_rdata)
   );

   typedef struct {
      bit          v;
      bit          w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } req_t;

   typedef struct {
      bit          v;
      bit          w;
      bit          owner_b;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } pend_t;

   // reference model state
   pend_t pend;
   int    starve;
   bit    rsp_v;
   bit    rsp_b;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      pend   = '{default: 0};
      starve = 0;
      rsp_v  = 1'b0;
      rsp_b  = 1'b0;
   endtask

   function automatic req_t mk(input bit v, input bit w, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
      req_t r;
      r.v = v; r.w = w; r.addr = addr; r.data = data; r.mask = mask;
      return r;
   endfunction

   function automatic req_t rand_req();
      return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                4'($urandom));
   endfunction

   task automatic drive_idle();
      a_valid = 0; a_write = 0; a_address = 0; a_writedata = 0; a_writemask = 0;
      b_valid = 0; b_write = 0; b_address = 0; b_writedata = 0; b_writemask = 0;
      m_ready = 0; m_rdata = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"},     m_valid, 0);
      check({tag, "_a_ready"},     a_ready, 0);
      check({tag, "_b_ready"},     b_ready, 0);
      check({tag, "_a_rvalid"},    a_rvalid, 0);
      check({tag, "_b_rvalid"},    b_rvalid, 0);
      check({tag, "_m_write"},     m_write, 0);
      check({tag, "_m_writemask"}, m_writemask, 0);
      check({tag, "_m_address"},   m_address, 0);
      check({tag, "_m_writedata"}, m_writedata, 0);
   endtask

   // One clock cycle: drive at the falling edge, compare against the model, then advance
   // the model to what must hold after the next rising edge.
   task automatic step(input req_t a, input req_t b, input logic mr, input logic [31:0] rd,
                       output logic got_ar, output logic got_br);
      bit free, ovr, ga, gb;
      @(negedge clock);
      a_valid = a.v; a_write = a.w; a_address = a.addr; a_writedata = a.data; a_writemask = a.mask;
      b_valid = b.v; b_write = b.w; b_address = b.addr; b_writedata = b.data; b_writemask = b.mask;
      m_ready = mr;  m_rdata = rd;
      #1;
      free = !pend.v || mr;
      ovr  = STARVE_EN && (starve == STARVE_MAX);
      ga   = a.v && !(ovr && b.v);
      gb   = b.v && !ga;
      check("a_ready", a_ready, free && ga);
      check("b_ready", b_ready, free && gb);
      check("m_valid", m_valid, pend.v);
      if (pend.v) begin
         check("m_write",     m_write, pend.w);
         check("m_address",   m_address, pend.addr);
         check("m_writedata", m_writedata, pend.data);
         check("m_writemask", m_writemask, pend.mask);
      end
      check("a_rvalid", a_rvalid, rsp_v && !rsp_b);
      check("b_rvalid", b_rvalid, rsp_v && rsp_b);
      if (rsp_v && !rsp_b) check("a_rdata", a_rdata, rd);
      if (rsp_v && rsp_b)  check("b_rdata", b_rdata, rd);
      got_ar = a_ready;
      got_br = b_ready;
      // advance the model
      rsp_v = pend.v && mr && !pend.w;
      if (pend.v && mr) rsp_b = pend.owner_b;
      if (free) begin
         starve = (b.v && ga) ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
         if (ga) begin
            pend.v = 1; pend.w = a.w; pend.owner_b = 0; pend.addr = a.addr;
            pend.data = a.data; pend.mask = a.w ? a.mask : 4'h0;
         end else if (gb) begin
            pend.v = 1; pend.w = b.w; pend.owner_b = 1; pend.addr = b.addr;
            pend.data = b.data; pend.mask = b.w ? b.mask : 4'h0;
         end else begin
            pend.v = 0;
         end
      end
   endtask

   initial begin
      req_t idle, ra, rb;
      logic ar, br;
      int   nb, nrsp;

      idle = mk(0, 0, 0, 0, 0);
      model_reset();
      drive_idle();
      // hold reset with live requests: everything must stay quiet
      a_valid = 1; b_valid = 1; m_ready = 1;
      #7;
      check_reset_outputs("reset");
      drive_idle();
      #1 reset_n = 1'b1;

      // A single read straight out of reset: grant on the first edge, data two cycles later
      step(mk(1, 0, 32'h8000_0010, 32'h0, 4'hF), idle, 1, $urandom, ar, br);
      check("first_grant_a_ready", ar, 1);
      step(idle, idle, 1, $urandom, ar, br);
      step(idle, idle, 1, 32'h1234_5678, ar, br);
      check("load_a_rvalid", a_rvalid, 1);
      check("load_a_rdata",  a_rdata, 32'h1234_5678);
      check("load_b_rvalid", b_rvalid, 0);

      // A and B both requesting continuously
      step(idle, idle, 1, $urandom, ar, br);
      nb = 0;
      for (int i = 0; i < 15; i++) begin
         ra = mk(1, 0, 32'h1000 + i, 0, 0);
         rb = mk(1, 0, 32'h2000 + i, 0, 0);
         step(ra, rb, 1, $urandom, ar, br);
         if (br) nb++;
      end
      check("contend_b_grants", nb, STARVE_EN ? 3 : 0);
      step(idle, idle, 1, $urandom, ar, br);
      step(idle, idle, 1, $urandom, ar, br);

      // B write held by a three-cycle memory stall
      step(idle, mk(1, 1, 32'h8000_0100, 32'hCAFE_F00D, 4'hF), 1, $urandom, ar, br);
      check("stall_b_accept", br, 1);
      for (int i = 0; i < 3; i++) begin
         step(rand_req(), rand_req(), 0, $urandom, ar, br);
         check("stall_m_address",   m_address, 32'h8000_0100);
         check("stall_m_writedata", m_writedata, 32'hCAFE_F00D);
         check("stall_no_ready",    {ar, br}, 0);
      end
      step(idle, idle, 1, $urandom, ar, br);
      check("stall_release_m_valid", m_valid, 1);
      step(idle, idle, 1, $urandom, ar, br);
      check("stall_write_no_rvalid", {a_rvalid, b_rvalid}, 0);

      // Reset right after a read has been accepted
      step(mk(1, 0, 32'h8000_0200, 0, 0), idle, 1, $urandom, ar, br);
      check("midreset_accept", ar, 1);
      @(negedge clock);
      reset_n = 1'b0;
      a_valid = 1; m_ready = 1;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      drive_idle();
      @(posedge clock);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(idle, idle, 1, $urandom, ar, br);
         check("midreset_no_rvalid", {a_rvalid, b_rvalid}, 0);
      end

      // Alternating A/B reads at full throughput
      nrsp = 0;
      for (int i = 0; i < 10; i++) begin
         ra = (i < 8 && i % 2 == 0) ? mk(1, 0, 32'h3000 + i, 0, 4'hF) : idle;
         rb = (i < 8 && i % 2 == 1) ? mk(1, 0, 32'h4000 + i, 0, 4'hF) : idle;
         step(ra, rb, 1, $urandom, ar, br);
         if (a_rvalid ^ b_rvalid) nrsp++;
      end
      check("alt_rsp_count", nrsp, 8);

      // Randomized traffic with occasional memory back-pressure
      for (int i = 0; i < 400; i++)
         step(rand_req(), rand_req(), ($urandom_range(0, 3) != 0), $urandom, ar, br);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
